// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fifo_pkg
// Purpose : Shared definitions for the dual-clock FIFO pointer logic.
//           Holds the default address width, depth, pointer type and the
//           Gray/binary conversion helpers used by both read and write sides.
// Ports   : none (package)
// Rev     : 1.0  initial parameterised release
// ============================================================================
package fifo_pkg;

  localparam int c_fifo_addrsize = 4;
  localparam int DEPTH           = 1 << c_fifo_addrsize;
  localparam int c_conv_w        = 32;

  typedef logic [c_fifo_addrsize:0] ptr_t;

  // Conversions work on a wide vector. Callers zero-extend narrower pointers
  // and truncate the result; leading zeros leave the low bits unaffected.
  function automatic logic [c_conv_w-1:0] bin2gray(input logic [c_conv_w-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [c_conv_w-1:0] gray2bin(input logic [c_conv_w-1:0] g);
    logic [c_conv_w-1:0] b;
    b[c_conv_w-1] = g[c_conv_w-1];
    for (int i = c_conv_w - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_gray_bus.sv
`default_nettype none
// ============================================================================
// Module  : sync_gray_bus
// Purpose : Multi-flop synchroniser for a Gray-coded bus. Plain flop chain,
//           no logic between stages.
// Ports   : clk   - destination-domain clock
//           rst   - synchronous active-high reset, clears every stage
//           i_d   - asynchronous Gray-coded input bus
//           o_q   - synchronised bus (last stage)
// Rev     : 1.0  initial release
// ============================================================================
module sync_gray_bus #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        r_q[i] <= '0;
      end
    end else begin
      r_q[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_q[i] <= r_q[i-1];
      end
    end
  end

  assign o_q = r_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/rptr_empty_ctl.sv
`default_nettype none
// ============================================================================
// Module  : rptr_empty_ctl
// Purpose : Read-side control for the dual-clock FIFO. Owns the binary and
//           Gray read pointers, synchronises the write Gray pointer into
//           rclk and produces registered empty / almost-empty / count.
// Ports   : rclk, rrst       - read clock, synchronous active-high reset
//           rinc             - pop request (ignored while empty)
//           wptr_gray        - write pointer, Gray coded, async to rclk
//           raddr            - RAM read address
//           rptr             - registered Gray read pointer to write domain
//           rempty, raempty  - empty / almost-empty flags
//           rcount           - occupancy seen from the read side
//           rudf, rudf_clr   - sticky underflow flag and its clear
//                              (only when RPTR_UDF_EN is defined)
// Macro   : RPTR_UDF_EN enables the underflow flag logic and ports.
// Rev     : 1.0  parameterised successor to the fixed 4-bit block
// ============================================================================
module rptr_empty_ctl
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE      = c_fifo_addrsize,
  parameter int SYNC_STAGES   = 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   wptr_gray,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic                raempty,
  output logic [ADDRSIZE:0]   rcount
`ifdef RPTR_UDF_EN
  ,
  output logic                rudf,
  input  logic                rudf_clr
`endif
);

  localparam int                c_pw        = ADDRSIZE + 1;
  localparam logic [ADDRSIZE:0] c_ae_thresh = c_pw'(AEMPTY_THRESH);

  logic [ADDRSIZE:0] r_rbin;
  logic [ADDRSIZE:0] r_rptr;
  logic [ADDRSIZE:0] r_rcount;
  logic              r_rempty;
  logic              r_raempty;

  logic [ADDRSIZE:0] w_wsync;
  logic [ADDRSIZE:0] w_wbin;
  logic [ADDRSIZE:0] w_rbnext;
  logic [ADDRSIZE:0] w_rgnext;
  logic [ADDRSIZE:0] w_count;
  logic              w_pop;

  sync_gray_bus #(
    .WIDTH  (c_pw),
    .STAGES (SYNC_STAGES)
  ) u_wsync (
    .clk (rclk),
    .rst (rrst),
    .i_d (wptr_gray),
    .o_q (w_wsync)
  );

  // Everything below works on the next pointer value so the flags reflect
  // a pop on the same edge the pointer advances.
  always_comb begin
    w_pop    = rinc & ~r_rempty;
    w_rbnext = r_rbin + {{ADDRSIZE{1'b0}}, w_pop};
    w_rgnext = c_pw'(bin2gray(c_conv_w'(w_rbnext)));
    w_wbin   = c_pw'(gray2bin(c_conv_w'(w_wsync)));
    // Wraps modulo 2^(ADDRSIZE+1); a full FIFO yields exactly DEPTH.
    w_count  = w_wbin - w_rbnext;
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_rbin    <= '0;
      r_rptr    <= '0;
      r_rempty  <= 1'b1;
      r_raempty <= 1'b1;
      r_rcount  <= '0;
    end else begin
      r_rbin    <= w_rbnext;
      r_rptr    <= w_rgnext;
      r_rempty  <= (w_rgnext == w_wsync);
      r_raempty <= (w_count <= c_ae_thresh);
      r_rcount  <= w_count;
    end
  end

  assign raddr   = r_rbin[ADDRSIZE-1:0];
  assign rptr    = r_rptr;
  assign rempty  = r_rempty;
  assign raempty = r_raempty;
  assign rcount  = r_rcount;

`ifdef RPTR_UDF_EN
  logic r_rudf;

  // Set has priority over clear so an underflow in the clearing cycle
  // is not lost.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_rudf <= 1'b0;
    end else if (rinc & r_rempty) begin
      r_rudf <= 1'b1;
    end else if (rudf_clr) begin
      r_rudf <= 1'b0;
    end
  end

  assign rudf = r_rudf;
`endif

endmodule
`default_nettype wire

// File: doc/rptr_empty_ctl.md
Name: rptr_empty_ctl

Overview:
- Read-side control block for the dual-clock FIFO.
- Owns the binary and Gray read pointers and synchronises the write-domain Gray pointer into rclk internally.
- Generates registered empty, almost-empty and occupancy-count outputs.
- Parametrised successor to the fixed 4-bit read-pointer/empty logic: configurable depth, synchroniser length and almost-empty threshold.

Parameters:
- ADDRSIZE, 4: FIFO address width. Depth = 2^ADDRSIZE. Pointers are ADDRSIZE+1 bits.
- SYNC_STAGES, 2: flop stages synchronising wptr_gray into rclk. Legal range is 2..4.
- AEMPTY_THRESH, 2: raempty asserts when occupancy <= AEMPTY_THRESH. Legal range is 0..2^ADDRSIZE-1.

Ports:
- rclk, input, 1: read-domain clock; all state is on its rising edge.
- rrst, input, 1: synchronous, active-high reset.
- rinc, input, 1: read request; pops one entry when rempty=0.
- wptr_gray, input, ADDRSIZE+1: write pointer in Gray code, asynchronous to rclk.
- raddr, output, ADDRSIZE: RAM read address, equal to rbin[ADDRSIZE-1:0].
- rptr, output, ADDRSIZE+1: registered Gray read pointer, sent to the write domain.
- rempty, output, 1: FIFO empty, registered.
- raempty, output, 1: FIFO almost empty, registered.
- rcount, output, ADDRSIZE+1: occupancy as seen from the read side, 0..2^ADDRSIZE.
- rudf, output, 1: sticky underflow flag; present only with RPTR_UDF_EN.
- rudf_clr, input, 1: clears rudf; present only with RPTR_UDF_EN.

Behaviour:
- Reset: rrst=1 at a rising rclk edge sets the following, overriding any rinc in the same cycle:
  - rbin=0, rptr=0
  - every synchroniser stage=0
  - rempty=1, raempty=1, rcount=0, rudf=0
- Reset can be asserted mid-operation; it discards all pointer state with no drain.
- Pop qualifier: pop = rinc & ~rempty. rinc while rempty=1 is ignored and the pointer holds.
- Next-state arithmetic, all modulo 2^(ADDRSIZE+1) so the pointer wraps naturally:
  - rbnext = rbin + pop
  - rgnext = (rbnext>>1) ^ rbnext
  - rbin <= rbnext, rptr <= rgnext
- Synchroniser:
  - wq[0] <= wptr_gray; wq[i] <= wq[i-1]
  - wsync = wq[SYNC_STAGES-1]
  - No logic is allowed between stages.
- Empty: rempty <= (rgnext == wsync). A pop that empties the FIFO raises rempty on the same edge the pointer advances.
- Count:
  - wbin = gray2bin(wsync)
  - rcount <= wbin - rbnext, modulo 2^(ADDRSIZE+1)
  - raempty <= (that value <= AEMPTY_THRESH)
- Latency: a wptr_gray change becomes visible in rempty/rcount after SYNC_STAGES+1 rclk edges.
- Flag safety: flags are pessimistic. rempty may stay high longer than true occupancy warrants, but must never deassert early.
- Full FIFO: when MSBs differ and the low bits are equal, rcount = 2^ADDRSIZE and rempty=0.
- Pointer wrap: at rbin=2^(ADDRSIZE+1)-1, a pop wraps rbin to 0 and rptr to 0 (Gray code of 0).
- Illegal input: wptr_gray is assumed Gray-coded from the write domain. A multi-bit change in one rclk cycle is illegal, but must not deadlock the block.

Optional Feature:
- Macro: RPTR_UDF_EN.
- Defined:
  - rudf and rudf_clr ports exist.
  - rudf <= 1 on any edge with rinc & rempty.
  - rudf_clr=1 clears rudf. If set and clear occur in the same cycle, set wins.
  - rrst clears rudf.
- Undefined: neither port exists and no underflow logic is generated.

Decomposition:
- Shared package fifo_pkg holds:
  - a ptr_t typedef sized by ADDRSIZE+1
  - localparam DEPTH = 1<<ADDRSIZE
  - gray/binary conversion functions, shared with the write-side full block
- One sub-module, sync_gray_bus: an SYNC_STAGES-deep, width-parametrised synchroniser with synchronous active-high reset.
- gray2bin is a package function, not a module.

Test Plan (ADDRSIZE=4, SYNC_STAGES=2, AEMPTY_THRESH=2):
- Reset:
  - Stimulus: assert rrst 2 cycles with rinc=1 and wptr_gray=5'b00110.
  - Response: rptr=0, raddr=0, rempty=1, raempty=1, rcount=0 throughout reset.
  - Then wptr_gray is held: rempty=0, rcount=4, raempty=0 after 3 edges.
- Write latency:
  - Stimulus: from empty, step wptr_gray 0→1 (Gray of 1).
  - Response: rempty stays 1 for 2 edges, drops on the 3rd edge; rcount=1, raempty=1.
- Drain:
  - Stimulus: with wptr_gray = Gray(3), pulse rinc 3 cycles.
  - Response: raddr steps 0,1,2,3; rcount steps 3,2,1,0; rempty=1 on the edge of the 3rd pop.
  - Then a 4th rinc leaves raddr=3.
- Full and wrap:
  - Stimulus: set wptr_gray = Gray(16).
  - Response: rcount=16, rempty=0.
  - Then 32 total pops with the write pointer kept ahead: rptr wraps to 5'b00000 and rbin is 0 after pop 32.
- Almost empty:
  - Stimulus: occupancy 4, then pop.
  - Response: raempty=0 at counts 4 and 3, then 1 at count 2.
- Underflow (RPTR_UDF_EN defined):
  - Stimulus: rinc=1 while empty.
  - Response: rudf=1 next edge, pointer unchanged.
  - Then rudf_clr=1 with rinc=0: rudf=0.
  - Then rudf_clr=1 and rinc=1 together while empty: rudf stays 1.
